// File: rtl/spi_xfer_arbiter.sv
// Two-requester SPI mode-0 master: round-robin grant, 1..16 bit MSB-first transfers.
// Latency: accept -> rsp pulse after 1 + DIV + 2*DIV*(len+1) cycles.
// Backpressure: reqX_ready only in IDLE for the granted requester; others hold valid.
module spi_xfer_arbiter #(
  parameter int NSS = 8,
  parameter int DIV = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [2:0]     req0_ss,
  input  logic [3:0]     req0_len,
  input  logic [15:0]    req0_tx,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [2:0]     req1_ss,
  input  logic [3:0]     req1_len,
  input  logic [15:0]    req1_tx,
  output logic           rsp0_valid,
  output logic           rsp1_valid,
  output logic [15:0]    rsp_data,
  output logic           sck,
  output logic           mosi,
  input  logic           miso,
  output logic [NSS-1:0] ss_n
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_t;

  localparam int            DW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_M1 = DW'(DIV - 1);

  state_t         state_q, state_d;
  logic [DW-1:0]  div_q, div_d;       // cycles left in the current phase
  logic [3:0]     bit_q, bit_d;       // index of the bit currently on the wire
  logic [2:0]     ss_q, ss_d;
  logic [15:0]    tx_q, tx_d;
  logic           own_q, own_d;       // 1 = req1 owns the running transfer
  logic           last_q, last_d;     // 1 = req1 was granted last
  logic [15:0]    shift_q, shift_d;   // received bits, newest in bit 0
  logic           sck_q, sck_d;
  logic           mosi_q, mosi_d;
  logic [NSS-1:0] ssn_q, ssn_d;
  logic           rsp0_q, rsp0_d;
  logic           rsp1_q, rsp1_d;
  logic [15:0]    rdata_q, rdata_d;

  logic grant0, grant1, idle, sel_active;

  // On a tie the requester not served last wins.
  assign grant0 = req0_valid & (~req1_valid | last_q);
  assign grant1 = req1_valid & ~grant0;
  assign idle   = (state_q == IDLE) & ~reset;

  assign req0_ready = idle & grant0;
  assign req1_ready = idle & grant1;

  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;
  assign rsp_data   = rdata_q;
  assign sck        = sck_q;
  assign mosi       = mosi_q;
  assign ss_n       = ssn_q;

  // Next state plus registered-output decode from the next state, so pins change on phase entry.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    ss_d    = ss_q;
    tx_d    = tx_q;
    own_d   = own_q;
    last_d  = last_q;
    shift_d = shift_q;
    mosi_d  = mosi_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          state_d = SETUP;
          div_d   = DIV_M1;
          ss_d    = grant0 ? req0_ss  : req1_ss;
          bit_d   = grant0 ? req0_len : req1_len;
          tx_d    = grant0 ? req0_tx  : req1_tx;
          own_d   = grant1;
          last_d  = grant1;
          shift_d = '0;
        end
      end
      SETUP, HIGH: begin
        if (div_q == '0) begin
          state_d = (state_q == SETUP) ? HIGH : LOW;
          div_d   = DIV_M1;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      LOW: begin
        if (div_q == '0) begin
          if (bit_q == 4'd0) begin
            state_d = DONE;
          end else begin
            state_d = HIGH;
            bit_d   = bit_q - 4'd1;
            div_d   = DIV_M1;
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // MOSI moves at SETUP entry (first bit) and on each SCK fall; holds after the last bit.
    if (state_q == IDLE && state_d == SETUP) begin
      mosi_d = tx_d[bit_d];
    end else if (state_q == HIGH && state_d == LOW && bit_q != 4'd0) begin
      mosi_d = tx_q[bit_q - 4'd1];
    end

    // MISO is taken on the same edge that raises SCK, before the slave reacts.
    if (state_d == HIGH && state_q != HIGH) begin
      shift_d = {shift_q[14:0], miso};
    end

    if (state_d == DONE) begin
      rdata_d = shift_q;
    end

    sck_d  = (state_d == HIGH);
    rsp0_d = (state_d == DONE) & ~own_d;
    rsp1_d = (state_d == DONE) &  own_d;
  end

  assign sel_active = (state_d == SETUP) | (state_d == HIGH) | (state_d == LOW);

  // Slave select decode; an index beyond NSS asserts nothing.
  always_comb begin
    ssn_d = '1;
    for (int i = 0; i < NSS; i++) begin
      if (sel_active && int'(ss_d) == i) begin
        ssn_d[i] = 1'b0;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      ss_q    <= '0;
      tx_q    <= '0;
      own_q   <= 1'b0;
      last_q  <= 1'b1;
      shift_q <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      ssn_q   <= '1;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      ss_q    <= ss_d;
      tx_q    <= tx_d;
      own_q   <= own_d;
      last_q  <= last_d;
      shift_q <= shift_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      ssn_q   <= ssn_d;
      rsp0_q  <= rsp0_d;
      rsp1_q  <= rsp1_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
